// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 codes,
// the captured request record and the access-size decode.
package lsu_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic                       we;
        logic [2:0]                 funct3;
        logic [NUM_LANES-1:0]       wstrb;
        logic [NUM_LANES*8-1:0]     wdata;
    } lsu_req_t;

    // Unlisted encodings fall back to a full word.
    function automatic lsu_size_e lsu_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: lsu_size = SZ_B;
            F3_H, F3_HU: lsu_size = SZ_H;
            default:     lsu_size = SZ_W;
        endcase
    endfunction

    function automatic logic lsu_signed(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane formatting: store replication/byte enables and
// load byte/half extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]               st_funct3,
    input  logic [1:0]               st_off,
    input  logic [31:0]              st_data,
    output logic [31:0]              st_wdata,
    output logic [NUM_LANES-1:0]     st_wstrb,
    input  logic [2:0]               ld_funct3,
    input  logic [1:0]               ld_off,
    input  logic [31:0]              ld_word,
    output logic [31:0]              ld_data
);

    lsu_size_e   st_size;
    lsu_size_e   ld_size;
    logic [31:0] ld_shift;
    logic        ld_sx;

    assign st_size = lsu_size(st_funct3);
    assign ld_size = lsu_size(ld_funct3);
    assign ld_sx   = lsu_signed(ld_funct3);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign st_wdata[8*i +: 8] = (st_size == SZ_B) ? st_data[7:0] :
                                    (st_size == SZ_H) ? st_data[8*(i%2) +: 8] :
                                                        st_data[8*i +: 8];
        assign st_wstrb[i] = (st_size == SZ_B) ? (st_off == 2'(i)) :
                             (st_size == SZ_H) ? (st_off[1] == 1'(i/2)) :
                                                 1'b1;
    end

    assign ld_shift = ld_word >> {ld_off, 3'b000};

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            SZ_B:    ld_data = {{24{ld_sx & ld_shift[7]}}, ld_shift[7:0]};
            SZ_H:    ld_data = {{16{ld_sx & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the single-cycle datapath and a multi-cycle memory bus.
// Define LSU_TIMEOUT_EN to bound the response wait by TIMEOUT_CYCLES.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_error,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       load_q;
    logic              access, misal_raw, capture, timeout;
    lsu_size_e         size_in;
    logic [31:0]       st_wdata, ld_fmt;
    logic [3:0]        st_wstrb;

    assign access  = mem_read | mem_write;
    assign size_in = lsu_size(funct3);
    assign misal_raw = ((size_in == SZ_H) & addr[0]) |
                       ((size_in == SZ_W) & (addr[1:0] != 2'b00));

    lsu_align u_align (
        .st_funct3 (funct3),
        .st_off    (addr[1:0]),
        .st_data   (store_data),
        .st_wdata  (st_wdata),
        .st_wstrb  (st_wstrb),
        .ld_funct3 (req_q.funct3),
        .ld_off    (addr_q[1:0]),
        .ld_word   (bus_rdata),
        .ld_data   (ld_fmt)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    // Counter is zero on the first WAIT cycle because it is held clear in REQ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            else                 wait_cnt_q <= '0;
            err_q <= timeout;
        end
    end

    assign timeout   = (state_q == WAIT) && !bus_rsp_valid &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus_error = err_q;
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        misaligned    = 1'b0;
        bus_req_valid = 1'b0;
        capture       = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misal_raw) begin
                        misaligned = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        capture = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall         = 1'b1;
                bus_req_valid = 1'b1;
                if (bus_req_ready) state_d = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (bus_rsp_valid || timeout) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are frozen at issue so the bus sees stable values in REQ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            req_q  <= '0;
            load_q <= '0;
        end else begin
            if (capture) begin
                addr_q       <= addr;
                req_q.we     <= mem_write;
                req_q.funct3 <= funct3;
                req_q.wstrb  <= mem_write ? st_wstrb : 4'b0000;
                req_q.wdata  <= mem_write ? st_wdata : 32'h0;
            end
            if (state_q == WAIT) begin
                if (bus_rsp_valid) begin
                    if (!req_q.we) load_q <= ld_fmt;
                end else if (timeout) begin
                    load_q <= '0;
                end
            end
        end
    end

    assign bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_we    = req_q.we;
    assign bus_wstrb = req_q.wstrb;
    assign bus_wdata = req_q.wdata;
    assign load_data = load_q;

endmodule
